// File: rtl/mesh_spike_collector_pkg.sv
// Shared types and widths for the mesh spike collector.
// SPIKE_TIMESTAMP_EN widens each buffered entry to {step, packet}.
package mesh_spike_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int PACKET_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH_DEF   = 16;
  localparam int FIFO_AW_DEF      = 4;
  localparam int STEP_CNT_W_DEF   = 16;

`ifdef SPIKE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // The packet occupies bits [pkt_w-1:0]; the step stamp, when present, sits above it.
  function automatic int entry_width(input int pkt_w, input int stamp_w);
    return pkt_w + (TS_EN ? stamp_w : 0);
  endfunction

endpackage

// File: rtl/mesh_spike_collector_fifo.sv
// Synchronous FIFO with registered pop data; the caller guarantees space on write.
module mesh_spike_collector_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic [AW:0]      count_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             rd_fire;

  // Empty is a registered view, so a write into an empty FIFO cannot be popped that cycle.
  assign rd_fire = rd_en_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({wr_en_i, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      rd_valid_q <= rd_fire;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/mesh_spike_collector.sv
// Router local-port spike collector: buffering, per-step statistics and run tracking.
// SPIKE_TIMESTAMP_EN stores the accepting step alongside each packet.
module mesh_spike_collector
  import mesh_spike_collector_pkg::*;
#(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int FIFO_AW      = FIFO_AW_DEF,
  parameter int FULL_MARGIN  = 1,
  parameter int STEP_NUMBER  = 32,
  parameter int STEP_CNT_W   = STEP_CNT_W_DEF
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic                                               step_tick,
  input  logic [PACKET_WIDTH-1:0]                            packet_in,
  input  logic                                               write_en,
  output logic                                               full,
  input  logic                                               rd_en,
  output logic [entry_width(PACKET_WIDTH, STEP_CNT_W)-1:0]   rd_data,
  output logic                                               rd_valid,
  output logic                                               empty,
  output logic [STEP_CNT_W-1:0]                              step_spike_count,
  output logic                                               step_done,
  output logic                                               done,
  output logic                                               overflow,
  output logic                                               result_output
);

  localparam int ENTRY_W = entry_width(PACKET_WIDTH, STEP_CNT_W);
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] FULL_C  = (FIFO_AW+1)'(FIFO_DEPTH - FULL_MARGIN);
  localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(STEP_NUMBER - 1);

  state_e                  state_q, state_d;
  logic [STEP_CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [STEP_CNT_W-1:0]   acc_q, acc_d, acc_inc;
  logic [STEP_CNT_W-1:0]   spike_cnt_q, spike_cnt_d;
  logic [PACKET_WIDTH-1:0] chk_q, chk_d;
  logic                    step_done_q, step_done_d;
  logic                    full_q, full_d;
  logic                    overflow_q, overflow_d;
  logic                    active, accept, drop;
  logic [FIFO_AW:0]        count, count_next;
  logic [ENTRY_W-1:0]      wr_data;

  assign active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign accept  = active && write_en && (count < DEPTH_C);
  assign drop    = active && write_en && (count == DEPTH_C);
  assign acc_inc = (acc_q == '1) ? acc_q : acc_q + 1'b1;

`ifdef SPIKE_TIMESTAMP_EN
  assign wr_data = {step_cnt_q, packet_in};
`else
  assign wr_data = packet_in;
`endif

  mesh_spike_collector_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (accept),
    .wr_data_i    (wr_data),
    .rd_en_i      (rd_en),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .empty_o      (empty),
    .count_o      (count),
    .count_next_o (count_next)
  );

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    acc_d       = accept ? acc_inc : acc_q;
    spike_cnt_d = spike_cnt_q;
    chk_d       = accept ? (chk_q ^ packet_in) : chk_q;
    step_done_d = 1'b0;
    overflow_d  = overflow_q | drop;
    full_d      = (count_next >= FULL_C);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          step_cnt_d = '0;
          acc_d      = '0;
          chk_d      = '0;
        end
      end
      ST_RUN: begin
        if (step_tick) begin
          // A packet accepted alongside the tick belongs to the closing step.
          spike_cnt_d = accept ? acc_inc : acc_q;
          step_done_d = 1'b1;
          acc_d       = '0;
          step_cnt_d  = step_cnt_q + 1'b1;
          if (step_cnt_q == LAST_STEP) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (empty && !write_en) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_cnt_q  <= '0;
      acc_q       <= '0;
      spike_cnt_q <= '0;
      chk_q       <= '0;
      step_done_q <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      acc_q       <= acc_d;
      spike_cnt_q <= spike_cnt_d;
      chk_q       <= chk_d;
      step_done_q <= step_done_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
    end
  end

  assign full             = full_q;
  assign step_spike_count = spike_cnt_q;
  assign step_done        = step_done_q;
  assign done             = (state_q == ST_DONE);
  assign overflow         = overflow_q;
  assign result_output    = ^chk_q;

endmodule
